// File: rtl/adc_spi_pkg.sv
// Shared types and default constants for the serial ADC read path.
package adc_spi_pkg;

  // Frame sequencer states; encodings are fixed so they read the same in any dump.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SCK_LOW  = 3'd2,
    ST_SCK_HIGH = 3'd3,
    ST_HOLD     = 3'd4,
    ST_GAP      = 3'd5
  } adc_state_t;

  // Defaults for the top-level ADC instance (2 MHz SCK from 48 MHz).
  localparam int ADC_CLK_DIV   = 12;
  localparam int ADC_CMD_BITS  = 8;
  localparam int ADC_DATA_BITS = 16;

  // Larger of two integers, used to size the shared phase timer.
  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
  input  logic clock,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clock) begin
    meta     <= async_in;
    sync_out <= meta;
  end

endmodule

// File: rtl/adc_spi_in.sv
// SPI mode-0 master that sends a command word and reads back an ADC sample.
module adc_spi_in
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV   = ADC_CLK_DIV,
  parameter int CMD_BITS  = ADC_CMD_BITS,
  parameter int DATA_BITS = ADC_DATA_BITS,
  parameter int CS_SETUP  = 4,
  parameter int CS_HOLD   = 4,
  parameter int CS_IDLE   = 24
) (
  input  logic                 Clock_48MHz,
  input  logic                 Reset,
  input  logic                 i_Start,
  input  logic [CMD_BITS-1:0]  i_Command,
  input  logic                 i_SPI_MISO,
  output logic                 o_SPI_CS,
  output logic                 o_SPI_Clock,
  output logic                 o_SPI_MOSI,
  output logic [DATA_BITS-1:0] o_Data = '0,
  output logic                 o_Valid,
  output logic                 o_Ready
);

  localparam int NBITS   = CMD_BITS + DATA_BITS;
  localparam int TMR_MAX = max_of(max_of(CLK_DIV, CS_SETUP), max_of(CS_HOLD, CS_IDLE));
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam int BIT_W   = $clog2(NBITS);

  localparam logic [TMR_W-1:0] DIV_LOAD   = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'(CS_HOLD - 1);
  localparam logic [TMR_W-1:0] IDLE_LOAD  = TMR_W'(CS_IDLE - 1);
  localparam logic [BIT_W-1:0] CMD_IDX    = BIT_W'(CMD_BITS);
  localparam logic [BIT_W-1:0] LAST_IDX   = BIT_W'(NBITS - 1);

  adc_state_t           state;
  logic [TMR_W-1:0]     timer;
  logic [BIT_W-1:0]     bit_idx;
  logic [CMD_BITS-1:0]  tx_shift;
  logic [CMD_BITS-1:0]  tx_next;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 miso_sync;
  logic                 phase_end;
  logic                 accept;
  logic                 sck_fall;
  logic                 hold_end;

  sync_2ff u_miso_sync (
    .clock    (Clock_48MHz),
    .async_in (i_SPI_MISO),
    .sync_out (miso_sync)
  );

  // Every phase loads the timer with length-1 and ends when it reaches zero.
  assign phase_end = (timer == '0);
  assign accept    = (state == ST_IDLE) && i_Start;
  assign sck_fall  = (state == ST_SCK_HIGH) && phase_end;
  assign hold_end  = (state == ST_HOLD) && phase_end;
  // Zero-filled shift: once every command bit is out, the MSB is 0 by itself.
  assign tx_next   = tx_shift << 1;

  // Frame sequencer: phase timing, bit counting and all SPI/handshake outputs.
  always_ff @(posedge Clock_48MHz) begin
    if (Reset) begin
      // Abort any frame; the gap timer is primed so Ready returns CS_IDLE cycles after release.
      state       <= ST_GAP;
      timer       <= IDLE_LOAD;
      bit_idx     <= '0;
      o_SPI_CS    <= 1'b1;
      o_SPI_Clock <= 1'b0;
      o_SPI_MOSI  <= 1'b0;
      o_Valid     <= 1'b0;
      o_Ready     <= 1'b0;
    end else begin
      o_Valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_Start) begin
            state      <= ST_SETUP;
            timer      <= SETUP_LOAD;
            bit_idx    <= '0;
            o_SPI_CS   <= 1'b0;
            o_Ready    <= 1'b0;
            o_SPI_MOSI <= i_Command[CMD_BITS-1];
          end
        end
        ST_SETUP: begin
          if (phase_end) begin
            state <= ST_SCK_LOW;
            timer <= DIV_LOAD;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_SCK_LOW: begin
          if (phase_end) begin
            state       <= ST_SCK_HIGH;
            timer       <= DIV_LOAD;
            o_SPI_Clock <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_SCK_HIGH: begin
          if (phase_end) begin
            o_SPI_Clock <= 1'b0;
            o_SPI_MOSI  <= tx_next[CMD_BITS-1];
            bit_idx     <= bit_idx + 1'b1;
            if (bit_idx == LAST_IDX) begin
              state <= ST_HOLD;
              timer <= HOLD_LOAD;
            end else begin
              state <= ST_SCK_LOW;
              timer <= DIV_LOAD;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_HOLD: begin
          if (phase_end) begin
            state    <= ST_GAP;
            timer    <= IDLE_LOAD;
            o_SPI_CS <= 1'b1;
            o_Valid  <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_GAP: begin
          if (phase_end) begin
            state   <= ST_IDLE;
            o_Ready <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= ST_GAP;
          timer <= IDLE_LOAD;
        end
      endcase
    end
  end

  // Shift registers and sample output; a reset on the same edge suppresses any update.
  always_ff @(posedge Clock_48MHz) begin
    if (!Reset) begin
      if (accept) begin
        tx_shift <= i_Command;
      end else if (sck_fall) begin
        tx_shift <= tx_next;
      end
      // Bits clocked in while the command is going out are dropped.
      if (sck_fall && (bit_idx >= CMD_IDX)) begin
        rx_shift <= (rx_shift << 1) | DATA_BITS'(miso_sync);
      end
      if (hold_end) begin
        o_Data <= rx_shift;
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_in.sv
// Bench for adc_spi_in: frame timing, data capture, ignored starts, back-to-back, abort, MISO skew.
`timescale 1ns/1ps
module tb_adc_spi_in;
  import adc_spi_pkg::*;

  localparam int DIV       = 12;
  localparam int CB        = 8;
  localparam int DB        = 16;
  localparam int SETUP     = 4;
  localparam int HOLD      = 4;
  localparam int IDLE      = 24;
  localparam int NBITS     = CB + DB;
  localparam int SCK_START = 1 + SETUP;
  localparam int SCK_LEN   = NBITS * 2 * DIV;
  localparam int VALID_OFS = 1 + SETUP + SCK_LEN + HOLD;
  localparam int READY_OFS = VALID_OFS + IDLE;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CB-1:0] cmd = '0;
  logic          miso = 1'b0;
  logic          o_SPI_CS, o_SPI_Clock, o_SPI_MOSI, o_Valid, o_Ready;
  logic [DB-1:0] o_Data;

  adc_spi_in #(
    .CLK_DIV(DIV), .CMD_BITS(CB), .DATA_BITS(DB),
    .CS_SETUP(SETUP), .CS_HOLD(HOLD), .CS_IDLE(IDLE)
  ) dut (
    .Clock_48MHz (clk),
    .Reset       (rst),
    .i_Start     (start),
    .i_Command   (cmd),
    .i_SPI_MISO  (miso),
    .o_SPI_CS    (o_SPI_CS),
    .o_SPI_Clock (o_SPI_Clock),
    .o_SPI_MOSI  (o_SPI_MOSI),
    .o_Data      (o_Data),
    .o_Valid     (o_Valid),
    .o_Ready     (o_Ready)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // ADC model: after each SCK fall from the 8th on, present the next sample bit after a skew.
  logic [DB-1:0] adc_word = '0;
  bit            jitter_en = 1'b0;
  int            jit_tab [8] = '{-3, 3, -2, 1, 0, 2, -1, 3};
  int            fall_cnt = 0;
  int            pend = -1;
  logic          pend_bit = 1'b0;
  logic          adc_sck_prev = 1'b0;

  always @(negedge clk) begin
    if (o_SPI_CS) begin
      fall_cnt = 0;
      pend     = -1;
    end else if (adc_sck_prev && !o_SPI_Clock) begin
      fall_cnt++;
      if (fall_cnt >= CB && fall_cnt < NBITS) begin
        pend_bit = adc_word[NBITS-1-fall_cnt];
        pend     = jitter_en ? (3 + jit_tab[fall_cnt % 8]) : 0;
      end
    end
    if (pend == 0) miso = pend_bit;
    if (pend >= 0) pend--;
    adc_sck_prev = o_SPI_Clock;
  end

  // Observers for frame-level facts.
  int             cs_fall_cnt = 0;
  int             cs_fall_last = 0;
  int             fall_q[$];
  int             valid_cnt = 0;
  int             sck_rises = 0;
  int             sck_period = 0;
  int             last_rise = 0;
  logic [CB-1:0]  mosi_bits = '0;
  logic           cs_prev = 1'b1;
  logic           sck_prev = 1'b0;

  always @(negedge clk) begin
    if (cs_prev && !o_SPI_CS) begin
      cs_fall_cnt++;
      cs_fall_last = cyc;
      fall_q.push_back(cyc);
      sck_rises = 0;
      mosi_bits = '0;
    end
    if (!sck_prev && o_SPI_Clock) begin
      sck_rises++;
      sck_period = cyc - last_rise;
      last_rise  = cyc;
      if (sck_rises <= CB) mosi_bits = {mosi_bits[CB-2:0], o_SPI_MOSI};
    end
    if (o_Valid) valid_cnt++;
    cs_prev  = o_SPI_CS;
    sck_prev = o_SPI_Clock;
  end

  // Cycle-offset model: each output is a function of the cycle distance from the accepted start.
  int            t0 = -1;
  int            ready_from = 32'h7fff_ffff;
  logic [CB-1:0] frame_cmd = '0;
  logic [DB-1:0] frame_word = '0;
  logic [DB-1:0] data_exp = '0;
  bit            armed = 1'b0;

  always @(negedge clk) begin
    logic e_cs, e_sck, e_mosi, e_valid, e_ready;
    int rel, o, b;
    if (armed) begin
      e_cs = 1'b1; e_sck = 1'b0; e_mosi = 1'b0; e_valid = 1'b0;
      if (t0 >= 0) begin
        rel = cyc - t0;
        if (rel >= 1 && rel < VALID_OFS) e_cs = 1'b0;
        if (rel >= 1 && rel < SCK_START) e_mosi = frame_cmd[CB-1];
        if (rel >= SCK_START && rel < SCK_START + SCK_LEN) begin
          o = rel - SCK_START;
          b = o / (2 * DIV);
          e_sck = ((o % (2 * DIV)) >= DIV);
          if (b < CB) e_mosi = frame_cmd[CB-1-b];
        end
        if (rel == VALID_OFS) begin
          e_valid  = 1'b1;
          data_exp = frame_word;
        end
      end
      e_ready = (cyc >= ready_from);
      chk("cs",    32'(o_SPI_CS),    32'(e_cs));
      chk("sck",   32'(o_SPI_Clock), 32'(e_sck));
      chk("mosi",  32'(o_SPI_MOSI),  32'(e_mosi));
      chk("valid", 32'(o_Valid),     32'(e_valid));
      chk("ready", 32'(o_Ready),     32'(e_ready));
      chk("data",  32'(o_Data),      32'(data_exp));
    end
    if (rst) begin
      t0         = -1;
      ready_from = cyc + 1 + IDLE;
      armed      = 1'b1;
    end else if (start && cyc >= ready_from) begin
      t0         = cyc;
      ready_from = cyc + READY_OFS;
      frame_cmd  = cmd;
      frame_word = adc_word;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_ready(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      if (o_Ready) at = cyc;
      else tick();
    end
  endtask

  task automatic wait_valid(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      if (o_Valid) at = cyc;
      else tick();
    end
  endtask

  task automatic start_frame(input logic [CB-1:0] c, input logic [DB-1:0] w, output int t);
    adc_word = w;
    cmd      = c;
    start    = 1'b1;
    t        = cyc;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int at, t, f0, v0;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_cs",    32'(o_SPI_CS),    32'd1);
    chk("rst_sck",   32'(o_SPI_Clock), 32'd0);
    chk("rst_mosi",  32'(o_SPI_MOSI),  32'd0);
    chk("rst_valid", 32'(o_Valid),     32'd0);
    chk("rst_ready", 32'(o_Ready),     32'd0);
    chk("rst_data",  32'(o_Data),      32'd0);
    wait_ready(100, at);
    chk("ready_after_reset", 32'(at), 32'd29);

    // Basic frame with ignored starts inside the frame and inside the gap.
    f0 = cs_fall_cnt;
    start_frame(8'hA5, 16'hC3E1, t);
    goto_cycle(t + 100);
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(600, at);
    chk("valid_latency", 32'(at - t), 32'd585);
    chk("data_basic",    32'(o_Data), 32'h0000_C3E1);
    goto_cycle(t + 590);
    start = 1'b1; tick(); start = 1'b0;
    wait_ready(100, at);
    chk("ready_latency", 32'(at - t),            32'd609);
    chk("one_frame",     32'(cs_fall_cnt - f0),  32'd1);
    chk("cs_fall_at",    32'(cs_fall_last - t),  32'd1);
    chk("sck_pulses",    32'(sck_rises),         32'd24);
    chk("sck_period",    32'(sck_period),        32'd24);
    chk("mosi_bits",     32'(mosi_bits),         32'h0000_00A5);
    chk("data_hold",     32'(o_Data),            32'h0000_C3E1);

    // Skewed MISO edges.
    jitter_en = 1'b1;
    start_frame(8'h3C, 16'h5A3C, t);
    wait_valid(700, at);
    chk("valid_jitter", 32'(at - t), 32'd585);
    chk("data_jitter",  32'(o_Data), 32'h0000_5A3C);
    wait_ready(100, at);
    jitter_en = 1'b0;

    // Start held high: three back-to-back frames.
    f0 = cs_fall_cnt;
    v0 = valid_cnt;
    adc_word = 16'h8001;
    cmd      = 8'hFF;
    start    = 1'b1;
    for (int i = 0; i < 3 * READY_OFS + 50 && cs_fall_cnt < f0 + 3; i++) tick();
    start = 1'b0;
    wait_ready(700, at);
    chk("b2b_frames", 32'(cs_fall_cnt - f0), 32'd3);
    if (fall_q.size() >= f0 + 3) begin
      chk("b2b_gap1", 32'(fall_q[f0+1] - fall_q[f0]),   32'd609);
      chk("b2b_gap2", 32'(fall_q[f0+2] - fall_q[f0+1]), 32'd609);
    end
    chk("b2b_valids", 32'(valid_cnt - v0), 32'd3);
    chk("b2b_data",   32'(o_Data),         32'h0000_8001);

    // Reset during a command bit with SCK high and MOSI high.
    v0 = valid_cnt;
    start_frame(8'hFF, 16'h1234, t);
    goto_cycle(t + 137);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_cs",   32'(o_SPI_CS),    32'd1);
    chk("abort_sck",  32'(o_SPI_Clock), 32'd0);
    chk("abort_mosi", 32'(o_SPI_MOSI),  32'd0);
    wait_ready(100, at);
    chk("abort_ready",    32'(at - t),         32'd162);
    chk("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("abort_data",     32'(o_Data),         32'h0000_8001);

    // Recovery frame after the abort.
    start_frame(8'h01, 16'h7FFE, t);
    wait_valid(700, at);
    chk("valid_recover", 32'(at - t), 32'd585);
    chk("data_recover",  32'(o_Data), 32'h0000_7FFE);
    wait_ready(100, at);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
